// File: rtl/jk_mod_counter_if.sv
// Control/status bundle for the JK modulo counter.
// Master drives controls; slave returns count and terminal flags.
interface jk_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             EN;
  logic             UP;
  logic             LOAD;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] QBAR;
  logic             TC;
  logic             WRAP;

  modport master (
    output EN,
    output UP,
    output LOAD,
    output D,
    input  Q,
    input  QBAR,
    input  TC,
    input  WRAP
  );

  modport slave (
    input  EN,
    input  UP,
    input  LOAD,
    input  D,
    output Q,
    output QBAR,
    output TC,
    output WRAP
  );
endinterface

// File: rtl/jk_mod_counter.sv
// Up/down modulo-N counter from a bank of JK stages.
// Define JK_MOD_COUNTER_SATURATE_EN to hold at the bounds.
module jk_stage (
  input  logic CLK,
  input  logic RST_N,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q <= 1'b0;
    end else begin
      unique case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign qbar = ~q;
endmodule

module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic              CLK,
  input  logic              RST_N,
  jk_mod_counter_if.slave   bus
);
  localparam logic [WIDTH:0]   MOD_X =
    (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP =
    WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE =
    WIDTH'(1);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] d_clamp;
  logic [WIDTH-1:0] up_nxt;
  logic [WIDTH-1:0] dn_nxt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] chg;
  logic             at_top;
  logic             at_zero;
  logic             ld;
  logic             cnt_up;
  logic             cnt_dn;
  logic             wrapping;
  logic             tc;

  assign at_top  = (q == TOP);
  assign at_zero = (q == '0);

  assign ld     = bus.LOAD;
  assign cnt_up = ~bus.LOAD & bus.EN & bus.UP;
  assign cnt_dn = ~bus.LOAD & bus.EN & ~bus.UP;

  // Out-of-range load values collapse to the top count
  assign d_clamp =
    ({1'b0, bus.D} >= MOD_X) ? TOP : bus.D;

`ifdef JK_MOD_COUNTER_SATURATE_EN
  assign up_nxt   = at_top  ? q : q + ONE;
  assign dn_nxt   = at_zero ? q : q - ONE;
  assign wrapping = 1'b0;
`else
  assign up_nxt   = at_top  ? '0  : q + ONE;
  assign dn_nxt   = at_zero ? TOP : q - ONE;
  assign wrapping = (cnt_up & at_top) |
                    (cnt_dn & at_zero);
`endif

  assign cnt_nxt = bus.UP ? up_nxt : dn_nxt;
  assign chg     = q ^ cnt_nxt;

  // Stages are only ever steered through J/K
  always_comb begin
    j = '0;
    k = '0;
    unique case (1'b1)
      ld: begin
        j = d_clamp;
        k = ~d_clamp;
      end
      cnt_up, cnt_dn: begin
        if (wrapping) begin
          j = chg & ~q;
          k = chg & q;
        end else begin
          j = chg;
          k = chg;
        end
      end
      default: begin
        j = '0;
        k = '0;
      end
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    jk_stage u_stage (
      .CLK  (CLK),
      .RST_N(RST_N),
      .j    (j[i]),
      .k    (k[i]),
      .q    (q[i]),
      .qbar (qbar[i])
    );
  end

  assign tc = bus.EN & ~bus.LOAD &
              ((bus.UP & at_top) |
               (~bus.UP & at_zero));

`ifdef JK_MOD_COUNTER_SATURATE_EN
  assign bus.WRAP = 1'b0;
`else
  logic wrap_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= tc;
    end
  end

  assign bus.WRAP = wrap_q;
`endif

  assign bus.Q    = q;
  assign bus.QBAR = qbar;
  assign bus.TC   = tc;
endmodule

// File: tb/tb_jk_mod_counter.sv
// Bench for jk_mod_counter with an arithmetic reference model.
// Honours JK_MOD_COUNTER_SATURATE_EN when defined.
module tb_jk_mod_counter;
  localparam int W = 4;
  localparam int M = 10;
`ifdef JK_MOD_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   m_q    = 0;
  bit   m_wrap = 1'b0;

  jk_mod_counter_if #(.WIDTH(W)) bus ();

  jk_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  function automatic bit model_tc();
    if (!bus.EN || bus.LOAD) return 1'b0;
    if (bus.UP) return (m_q == M - 1);
    return (m_q == 0);
  endfunction

  task automatic drive(input bit en, input bit up,
                       input bit ld, input int d);
    @(negedge CLK);
    bus.EN   = en;
    bus.UP   = up;
    bus.LOAD = ld;
    bus.D    = W'(d);
    #1;
  endtask

  task automatic tick();
    bit t;
    int dv;
    t  = model_tc();
    dv = int'(bus.D);
    if (bus.LOAD) begin
      m_q = (dv >= M) ? M - 1 : dv;
    end else if (bus.EN) begin
      if (bus.UP)
        m_q = (m_q == M - 1) ? (SAT ? m_q : 0) : m_q + 1;
      else
        m_q = (m_q == 0) ? (SAT ? 0 : M - 1) : m_q - 1;
    end
    m_wrap = SAT ? 1'b0 : t;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus.Q !== 4'd0 || bus.QBAR !== 4'hF ||
        bus.WRAP !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: Q=%h QBAR=%h WRAP=%b want 0 F 0",
               bus.Q, bus.QBAR, bus.WRAP);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    drive(0, 0, 1, 7);
    tick();
    checks++;
    if (bus.Q !== 4'd7) begin
      errors++;
      $display("FAIL reset_pre_load: Q=%0d want 7", bus.Q);
    end
    drive(0, 0, 0, 0);
    #2;
    RST_N = 1'b0;
    m_q    = 0;
    m_wrap = 1'b0;
    #1;
    checks++;
    if (bus.Q !== 4'd0 || bus.QBAR !== 4'hF ||
        bus.WRAP !== 1'b0 || bus.TC !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: Q=%h QBAR=%h WRAP=%b TC=%b want 0 F 0 0",
               bus.Q, bus.QBAR, bus.WRAP, bus.TC);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) begin
      drive(0, 0, 0, 0);
      tick();
      checks++;
      if (bus.Q !== 4'd0) begin
        errors++;
        $display("FAIL reset_hold: Q=%0d want 0", bus.Q);
      end
    end
  endtask

  task automatic test_up_wrap();
    drive(0, 0, 1, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, 0);
      checks++;
      if (bus.TC !== model_tc()) begin
        errors++;
        $display("FAIL up_tc: step %0d TC=%b want %b",
                 i, bus.TC, model_tc());
      end
      tick();
      checks++;
      if (bus.Q !== W'(m_q) || bus.WRAP !== m_wrap ||
          int'(bus.Q) >= M) begin
        errors++;
        $display("FAIL up_q: step %0d Q=%0d WRAP=%b want %0d %b",
                 i, bus.Q, bus.WRAP, m_q, m_wrap);
      end
    end
`ifndef JK_MOD_COUNTER_SATURATE_EN
    checks++;
    if (bus.Q !== 4'd0 || bus.WRAP !== 1'b1) begin
      errors++;
      $display("FAIL up_wrap_end: Q=%0d WRAP=%b want 0 1",
               bus.Q, bus.WRAP);
    end
    drive(0, 1, 0, 0);
    tick();
    checks++;
    if (bus.WRAP !== 1'b0) begin
      errors++;
      $display("FAIL up_wrap_pulse: WRAP=%b want 0", bus.WRAP);
    end
`endif
  endtask

  task automatic test_down_wrap();
    drive(0, 0, 1, 0);
    tick();
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 0, 0);
      checks++;
      if (bus.TC !== model_tc()) begin
        errors++;
        $display("FAIL down_tc: step %0d TC=%b want %b",
                 i, bus.TC, model_tc());
      end
      tick();
      checks++;
      if (bus.Q !== W'(m_q) || bus.WRAP !== m_wrap) begin
        errors++;
        $display("FAIL down_q: step %0d Q=%0d WRAP=%b want %0d %b",
                 i, bus.Q, bus.WRAP, m_q, m_wrap);
      end
`ifndef JK_MOD_COUNTER_SATURATE_EN
      if (i == 0) begin
        checks++;
        if (bus.Q !== 4'd9 || bus.WRAP !== 1'b1) begin
          errors++;
          $display("FAIL down_wrap: Q=%0d WRAP=%b want 9 1",
                   bus.Q, bus.WRAP);
        end
      end
`endif
    end
  endtask

  task automatic test_load();
    drive(1, 1, 1, 5);
    tick();
    checks++;
    if (bus.Q !== 4'd5 || bus.WRAP !== 1'b0) begin
      errors++;
      $display("FAIL load_5: Q=%0d WRAP=%b want 5 0",
               bus.Q, bus.WRAP);
    end
    drive(0, 0, 1, 13);
    tick();
    checks++;
    if (bus.Q !== 4'd9) begin
      errors++;
      $display("FAIL load_clamp: Q=%0d want 9", bus.Q);
    end
    drive(1, 1, 1, 3);
    checks++;
    if (bus.TC !== 1'b0) begin
      errors++;
      $display("FAIL load_tc: TC=%b want 0", bus.TC);
    end
    tick();
    checks++;
    if (bus.Q !== 4'd3 || bus.WRAP !== 1'b0) begin
      errors++;
      $display("FAIL load_3: Q=%0d WRAP=%b want 3 0",
               bus.Q, bus.WRAP);
    end
  endtask

  task automatic test_hold_dir();
    bit [3:0] exp_q [4] = '{4'd5, 4'd4, 4'd5, 4'd4};
    drive(0, 0, 1, 4);
    tick();
    repeat (3) begin
      drive(0, 1, 0, 0);
      checks++;
      if (bus.TC !== 1'b0) begin
        errors++;
        $display("FAIL hold_tc: TC=%b want 0", bus.TC);
      end
      tick();
      checks++;
      if (bus.Q !== 4'd4) begin
        errors++;
        $display("FAIL hold_q: Q=%0d want 4", bus.Q);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, (i % 2) == 0, 0, 0);
      tick();
      checks++;
      if (bus.Q !== exp_q[i] || bus.Q !== W'(m_q)) begin
        errors++;
        $display("FAIL dir_toggle: step %0d Q=%0d want %0d",
                 i, bus.Q, exp_q[i]);
      end
    end
  endtask

`ifdef JK_MOD_COUNTER_SATURATE_EN
  task automatic test_saturate();
    drive(0, 0, 1, 9);
    tick();
    repeat (3) begin
      drive(1, 1, 0, 0);
      checks++;
      if (bus.TC !== 1'b1) begin
        errors++;
        $display("FAIL sat_top_tc: TC=%b want 1", bus.TC);
      end
      tick();
      checks++;
      if (bus.Q !== 4'd9 || bus.WRAP !== 1'b0) begin
        errors++;
        $display("FAIL sat_top: Q=%0d WRAP=%b want 9 0",
                 bus.Q, bus.WRAP);
      end
    end
    drive(0, 0, 1, 0);
    tick();
    repeat (3) begin
      drive(1, 0, 0, 0);
      checks++;
      if (bus.TC !== 1'b1) begin
        errors++;
        $display("FAIL sat_zero_tc: TC=%b want 1", bus.TC);
      end
      tick();
      checks++;
      if (bus.Q !== 4'd0 || bus.WRAP !== 1'b0) begin
        errors++;
        $display("FAIL sat_zero: Q=%0d WRAP=%b want 0 0",
                 bus.Q, bus.WRAP);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0,
            int'($urandom_range(0, 15)));
      checks++;
      if (bus.TC !== model_tc()) begin
        errors++;
        $display("FAIL rand_tc: iter %0d TC=%b want %b",
                 i, bus.TC, model_tc());
      end
      tick();
      checks++;
      if (bus.Q !== W'(m_q) || bus.QBAR !== ~W'(m_q) ||
          bus.WRAP !== m_wrap) begin
        errors++;
        $display("FAIL rand_q: iter %0d Q=%0d QBAR=%h WRAP=%b want %0d %h %b",
                 i, bus.Q, bus.QBAR, bus.WRAP,
                 m_q, ~W'(m_q), m_wrap);
      end
    end
  endtask

  initial begin
    bus.EN   = 1'b0;
    bus.UP   = 1'b0;
    bus.LOAD = 1'b0;
    bus.D    = '0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_hold_dir();
`ifdef JK_MOD_COUNTER_SATURATE_EN
    test_saturate();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Synchronous up/down modulo-N counter built from a bank of JK flip-flop stages, one per bit, sharing one clock.
- Sits directly downstream of the single JK flip-flop cell. Its job is to generate each stage's J/K excitation from the current state and the control inputs, then consume the stage Q outputs as the count.
- Provides the count, its complement and terminal-count indications to the sequencing logic above it.

Parameters:
- WIDTH, 4, number of JK stages and count width; requires 2^WIDTH >= MODULUS.
- MODULUS, 10, count modulus; legal range 2..2^WIDTH; count range 0..MODULUS-1.

Ports:
- CLK  input  1  rising-edge clock for all stages.
- RST_N  input  1  asynchronous active-low reset.
- EN  input  1  count enable; a step occurs only when high.
- UP  input  1  direction: 1 = up, 0 = down; sampled only when EN=1.
- LOAD  input  1  synchronous parallel load; has priority over EN.
- D  input  WIDTH  load value.
- Q  output  WIDTH  current count (the stage Q outputs).
- QBAR  output  WIDTH  bitwise complement of Q (the stage Qbar outputs).
- TC  output  1  combinational terminal count.
- WRAP  output  1  registered one-cycle pulse indicating a wrap occurred on the previous edge.

Behaviour:
- Reset (RST_N=0), asynchronous and immediate regardless of CLK:
  - Q=0, QBAR=all ones, WRAP=0.
  - TC follows its equation (so 0 while EN=0).
  - Held while RST_N=0; counting resumes on the first rising CLK after deassertion.
- Each stage i is a JK flip-flop with the standard table: 00 hold, 01 reset, 10 set, 11 toggle. Next-state logic drives J[i]/K[i] only; no stage is written directly.
- Priority per rising edge: LOAD, then EN, then hold.
- LOAD=1:
  - Stage i uses J=D[i], K=~D[i] (set/reset mode).
  - If D >= MODULUS, load MODULUS-1 instead; load logic drives J/K from the clamped value.
  - WRAP is 0 on that edge.
- EN=1, LOAD=0, UP=1:
  - Q -> Q+1, or 0 when Q==MODULUS-1.
  - Excitation: J=K=1 on every bit that changes, J=K=0 elsewhere. On wrap, bits that must clear use J=0, K=1.
- EN=1, LOAD=0, UP=0:
  - Q -> Q-1, or MODULUS-1 when Q==0.
  - Same excitation rule as counting up.
- EN=0, LOAD=0: all J=K=0; Q holds.
- Latency: Q reflects the new value one CLK edge after the controlling inputs are sampled.
- TC = EN & ~LOAD & ((UP & Q==MODULUS-1) | (~UP & Q==0)). Purely combinational from the registered Q and the live inputs.
- WRAP: registered copy of TC. It is high for exactly the one cycle following a wrapping edge.
- Illegal out-of-range Q cannot arise from reset, load or counting.
- UP changing while EN=1: takes effect on the next edge; there is no pipeline to flush.
- QBAR equals ~Q at all times, including during reset.

Optional Feature:
- Macro: JK_MOD_COUNTER_SATURATE_EN.
- Defined:
  - Counting up at Q==MODULUS-1 holds (all J=K=0) instead of wrapping.
  - Counting down at Q==0 holds.
  - TC still asserts at those bounds; WRAP is tied to 0.
  - LOAD behaviour is unchanged.
- Not defined: wrap-around behaviour exactly as described above.

Test Plan:
- Reset: RST_N=0 asserted mid-cycle at Q=7 -> Q=0, QBAR=4'b1111, WRAP=0 immediately, without waiting for a CLK edge; after release with EN=0, Q stays 0.
- Up count and wrap (MODULUS=10, WIDTH=4): EN=1, UP=1 from Q=0 for 10 edges -> Q runs 1..9 then 0. TC=1 while Q=9. WRAP=1 for exactly the one cycle after 9->0. Q never reaches 10..15.
- Down count and wrap: EN=1, UP=0 from Q=0 -> next Q=9 with TC=1 beforehand and WRAP pulse after; then 8, 7, ...
- Load priority and clamp:
  - LOAD=1, EN=1, UP=1, D=5 -> Q=5, WRAP=0.
  - LOAD=1, D=13 -> Q=9.
  - LOAD=1 at Q=9 with UP=1 -> TC=0.
- Hold and direction change: EN=0 for 3 edges at Q=4 -> Q stays 4, TC=0. Then EN=1 with UP toggling each edge -> 5, 4, 5, 4.
- With JK_MOD_COUNTER_SATURATE_EN defined: Q=9, EN=1, UP=1 for 3 edges -> Q stays 9, TC=1, WRAP=0. Q=0 with UP=0 -> Q stays 0.
